// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX MAC address filter.
package eth_pkg;

  typedef enum logic [2:0] {
    HDR    = 3'd0,
    DECIDE = 3'd1,
    REPLAY = 3'd2,
    PASS   = 3'd3,
    DROP   = 3'd4
  } state_t;

  localparam int          ETH_ADDR_BYTES = 6;
  localparam logic [47:0] ETH_BCAST      = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_mac_addr_match.sv
// Combinational accept decision for a buffered destination MAC address.
// hdr[47:40] is the first destination byte seen on the wire; its bit 0 is
// the Ethernet group (multicast) bit.
module eth_mac_addr_match
  import eth_pkg::*;
(
  input  logic [47:0] hdr,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        accept_multicast,
  output logic        accept
);

  // Any one of the four acceptance rules is sufficient.
  always_comb begin
    accept = promisc
           | (hdr == ETH_BCAST)
           | (hdr[40] & accept_multicast)
           | (hdr == mac_addr);
  end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// RX destination-address filter: buffers the 6-byte destination MAC,
// decides accept/drop, then replays the header and forwards the rest of an
// accepted frame through a single output register, or discards the frame.
// Saturating accepted/dropped counters report status to software.
module eth_rx_mac_filter
  import eth_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [47:0]          mac_addr,
  input  logic                 promisc,
  input  logic                 accept_multicast,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] frames_accepted,
  output logic [CNT_WIDTH-1:0] frames_dropped
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     hdr_q [0:ETH_ADDR_BYTES-1];
  logic [47:0]    hdr_flat;
  logic           accept;

  logic           vld_p0;
  logic [7:0]     data_p0;
  logic           last_p0;
  logic           user_p0;

  logic           out_space;
  logic           in_fire;
  logic           hdr_we;
  logic           load;
  logic [7:0]     load_data;
  logic           load_last;
  logic           load_user;
  logic           acc_inc;
  logic           drop_inc;

  logic [CNT_WIDTH-1:0] acc_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  assign hdr_flat = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};

  eth_mac_addr_match u_match (
    .hdr              (hdr_flat),
    .mac_addr         (mac_addr),
    .promisc          (promisc),
    .accept_multicast (accept_multicast),
    .accept           (accept)
  );

  // The output register can take a new beat when empty or being drained.
  assign out_space = !vld_p0 || m_axis_tready;
  assign in_fire   = s_axis_tvalid && s_axis_tready;

  // Next-state, input ready, output-register load and counter strobes.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s_axis_tready = 1'b0;
    hdr_we        = 1'b0;
    load          = 1'b0;
    load_data     = 8'd0;
    load_last     = 1'b0;
    load_user     = 1'b0;
    acc_inc       = 1'b0;
    drop_inc      = 1'b0;
    unique case (state_q)
      HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          hdr_we = 1'b1;
          if (s_axis_tlast) begin
            // Frame ended inside the address field: runt.
            drop_inc = 1'b1;
            idx_d    = 3'd0;
          end else if (idx_q == 3'(ETH_ADDR_BYTES - 1)) begin
            state_d = DECIDE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DECIDE: begin
        idx_d = 3'd0;
        if (accept) begin
          state_d = REPLAY;
          acc_inc = 1'b1;
        end else begin
          state_d  = DROP;
          drop_inc = 1'b1;
        end
      end
      REPLAY: begin
        if (out_space) begin
          load      = 1'b1;
          load_data = hdr_q[idx_q];
          if (idx_q == 3'(ETH_ADDR_BYTES - 1)) begin
            state_d = PASS;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PASS: begin
        s_axis_tready = out_space;
        if (in_fire) begin
          load      = 1'b1;
          load_data = s_axis_tdata;
          load_last = s_axis_tlast;
          load_user = s_axis_tuser;
          if (s_axis_tlast) begin
            state_d = HDR;
            idx_d   = 3'd0;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = HDR;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = HDR;
        idx_d   = 3'd0;
      end
    endcase
  end

  // FSM state and header index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HDR;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Destination address capture; pure data, no reset needed.
  always_ff @(posedge clock) begin
    if (hdr_we) begin
      hdr_q[idx_q] <= s_axis_tdata;
    end
  end

  // Single output register feeding m_axis.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= 8'd0;
      last_p0 <= 1'b0;
      user_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
      last_p0 <= load_last;
      user_p0 <= load_user;
    end else if (m_axis_tready) begin
      vld_p0  <= 1'b0;
    end
  end

  // Saturating frame counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (acc_inc) begin
        acc_cnt_q <= sat_inc(acc_cnt_q);
      end
      if (drop_inc) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign m_axis_tvalid   = vld_p0;
  assign m_axis_tdata    = data_p0;
  assign m_axis_tlast    = last_p0;
  assign m_axis_tuser    = user_p0;
  assign frames_accepted = acc_cnt_q;
  assign frames_dropped  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed testbench for eth_rx_mac_filter. Counters are built 4 bits wide
// so that saturation can be reached with a handful of runt frames.
module tb_eth_rx_mac_filter;

  localparam int          CW  = 4;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

  logic          clock = 1'b0;
  logic          reset;
  logic [47:0]   mac_addr;
  logic          promisc;
  logic          accept_multicast;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [CW-1:0] frames_accepted;
  logic [CW-1:0] frames_dropped;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         first_vld_cyc = -1;
  int         hs6_cyc = 0;
  int         stall_cnt = 0;
  logic       bp_mode = 1'b0;
  logic [9:0] rx_q [$];
  logic [9:0] exp_q [$];

  eth_rx_mac_filter #(.CNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .mac_addr         (mac_addr),
    .promisc          (promisc),
    .accept_multicast (accept_multicast),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frames_accepted  (frames_accepted),
    .frames_dropped   (frames_dropped)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Sink ready: constant 1, or toggling every cycle in backpressure mode.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode) m_axis_tready = ~m_axis_tready;
      else         m_axis_tready = 1'b1;
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready)
        rx_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] d, input logic l, input logic u, input bit mark6);
    int w;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    w = 0;
    @(negedge clock);
    while (!s_axis_tready && w < 200) begin
      stall_cnt++;
      w++;
      @(negedge clock);
    end
    if (w >= 200) check("beat_timeout", {63'd0, s_axis_tready}, 64'd1);
    if (mark6) hs6_cyc = cyc;
    @(posedge clock);
    #1;
  endtask

  // Send a frame: 6 destination bytes then a deterministic payload.
  task automatic send_frame(input logic [47:0] dst, input int len, input logic u, input bit fwd);
    logic [7:0] b;
    logic       l;
    for (int i = 0; i < len; i++) begin
      b = (i < 6) ? dst[47 - 8*i -: 8] : 8'(i * 7 + 3);
      l = (i == len - 1);
      if (fwd) exp_q.push_back({u & l, l, b});
      send_beat(b, l, u & l, i == 5);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Let the output drain, then compare collected beats with expectations.
  task automatic check_out(input string tag);
    int err;
    int n;
    repeat (12) @(posedge clock);
    #1;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    err = 0;
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) err++;
    check({tag, "_beats"}, err, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset            = 1'b1;
    mac_addr         = MAC;
    promisc          = 1'b0;
    accept_multicast = 1'b0;
    s_axis_tdata     = 8'd0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast, 0);
    check("rst_tuser",  m_axis_tuser, 0);
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_acc",    frames_accepted, 0);
    check("rst_drop",   frames_dropped, 0);
    check("rst_sready", s_axis_tready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rx_q.delete();

    // Unicast match, 64 bytes
    first_vld_cyc = -1;
    stall_cnt = 0;
    send_frame(MAC, 64, 1'b0, 1'b1);
    check("ucast_stalls", stall_cnt, 7);  // 1 DECIDE + 6 REPLAY cycles
    check("ucast_latency", first_vld_cyc - hs6_cyc, 3);  // sample, DECIDE, load
    check_out("ucast");
    check("ucast_acc", frames_accepted, 1);

    // Unicast mismatch, 64 bytes
    stall_cnt = 0;
    send_frame(48'h02_00_00_00_00_02, 64, 1'b0, 1'b0);
    check("umiss_stalls", stall_cnt, 1);  // DECIDE only
    check_out("umiss");
    check("umiss_drop", frames_dropped, 1);
    check("umiss_acc",  frames_accepted, 1);

    // Broadcast
    send_frame(48'hFF_FF_FF_FF_FF_FF, 20, 1'b0, 1'b1);
    check_out("bcast");
    check("bcast_acc", frames_accepted, 2);

    // Multicast disabled, then enabled
    send_frame(48'h01_00_5E_00_00_01, 20, 1'b0, 1'b0);
    check_out("mcast_off");
    check("mcast_off_drop", frames_dropped, 2);
    accept_multicast = 1'b1;
    send_frame(48'h01_00_5E_00_00_01, 20, 1'b0, 1'b1);
    check_out("mcast_on");
    check("mcast_on_acc", frames_accepted, 3);
    accept_multicast = 1'b0;

    // Runts under promiscuous mode, then the shortest forwarded frame
    promisc = 1'b1;
    send_frame(48'h12_34_56_78_9A_BC, 4, 1'b0, 1'b0);
    check_out("runt4");
    check("runt4_drop", frames_dropped, 3);
    send_frame(48'h12_34_56_78_9A_BC, 6, 1'b0, 1'b0);
    check_out("runt6");
    check("runt6_drop", frames_dropped, 4);
    send_frame(48'h12_34_56_78_9A_BC, 7, 1'b0, 1'b1);
    check_out("promisc7");
    check("promisc7_acc", frames_accepted, 4);
    promisc = 1'b0;

    // Backpressure with tuser, then back-to-back second frame
    bp_mode = 1'b1;
    send_frame(MAC, 60, 1'b1, 1'b1);
    send_frame(MAC, 64, 1'b0, 1'b1);
    bp_mode = 1'b0;
    check_out("bp_b2b");
    check("bp_acc",  frames_accepted, 6);
    check("bp_drop", frames_dropped, 4);

    // Reset in PASS at byte 20
    for (int i = 0; i < 20; i++)
      send_beat((i < 6) ? MAC[47 - 8*i -: 8] : 8'(i), 1'b0, 1'b0, 1'b0);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mrst_tvalid", m_axis_tvalid, 0);
    check("mrst_tdata",  m_axis_tdata, 0);
    check("mrst_acc",    frames_accepted, 0);
    check("mrst_drop",   frames_dropped, 0);
    @(posedge clock);
    #1;
    rx_q.delete();
    exp_q.delete();
    send_frame(MAC, 64, 1'b0, 1'b1);
    check_out("post_rst");
    check("post_rst_acc",  frames_accepted, 1);
    check("post_rst_drop", frames_dropped, 0);

    // Counter saturation: 16 one-byte runts into a 4-bit counter
    for (int i = 0; i < 16; i++) send_frame(48'h0, 1, 1'b0, 1'b0);
    check_out("sat");
    check("sat_drop", frames_dropped, 15);
    check("sat_acc",  frames_accepted, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
